// File: rtl/pulse_to_level_pkg.sv
// ============================================================================
// Module      : pulse_to_level_pkg
// Description : State encodings and saturating helpers for the edge-detect family.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pulse_to_level_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HIGH = 2'b01,
        ST_GAP  = 2'b10
    } p2l_state_e;

    localparam logic [7:0] c_sat_max = 8'hFF;

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == c_sat_max) ? value : value + 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pulse_to_level_sat_cnt8.sv
// ============================================================================
// Module      : sat_cnt8
// Description : 8-bit saturating event counter; clear wins over increment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_cnt8
    import pulse_to_level_pkg::*;
(
    input  logic       i_clk,
    input  logic       rst_n,
    input  logic       i_clr,
    input  logic       i_inc,
    output logic [7:0] o_count
);

    logic [7:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!rst_n) begin
            r_count <= 8'd0;
        end else if (i_clr) begin
            r_count <= 8'd0;
        end else if (i_inc) begin
            r_count <= sat_inc(r_count);
        end
    end

    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/pulse_to_level.sv
// ============================================================================
// Module      : pulse_to_level
// Description : Stretches a trigger pulse into a level of programmable length,
//               followed by a forced-low guard interval.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_to_level
    import pulse_to_level_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MIN_LOW = 1
)
(
    input  logic             i_clk,
    input  logic             rst_n,
    input  logic             pulse,
    input  logic [WIDTH-1:0] len,
    input  logic             retrig,
    input  logic             clr_drop,
    output logic             level,
    output logic             done,
    output logic             busy,
    output logic [7:0]       drop_cnt,
    output logic [1:0]       p_STATE
);

    localparam logic [7:0] c_guard_load = 8'(MIN_LOW - 1);

    p2l_state_e       r_state;
    logic [WIDTH-1:0] r_hold;
    logic [7:0]       r_guard;
    logic             r_level;
    logic             r_done;
    logic             r_busy;

    logic [WIDTH-1:0] w_hold_load;
    logic             w_drop;

    // len=0 is treated as a one-cycle hold
    assign w_hold_load = (len == '0) ? '0 : len - WIDTH'(1);

    assign w_drop = pulse && (((r_state == ST_HIGH) && !retrig) || (r_state == ST_GAP));

    always_ff @(posedge i_clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_hold  <= '0;
            r_guard <= 8'd0;
            r_level <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (pulse) begin
                        r_state <= ST_HIGH;
                        r_hold  <= w_hold_load;
                        r_level <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (pulse && retrig) begin
                        r_hold <= w_hold_load;
                    end else if (r_hold != '0) begin
                        r_hold <= r_hold - WIDTH'(1);
                    end else begin
                        r_state <= ST_GAP;
                        r_guard <= c_guard_load;
                        r_level <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_guard != 8'd0) begin
                        r_guard <= r_guard - 8'd1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_hold  <= '0;
                    r_guard <= 8'd0;
                    r_level <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    sat_cnt8 u_drop_cnt (
        .i_clk   (i_clk),
        .rst_n   (rst_n),
        .i_clr   (clr_drop),
        .i_inc   (w_drop),
        .o_count (drop_cnt)
    );

    assign level   = r_level;
    assign done    = r_done;
    assign busy    = r_busy;
    assign p_STATE = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pulse_to_level.sv
// ============================================================================
// Module      : tb_pulse_to_level
// Description : Directed self-checking bench for pulse_to_level (MIN_LOW=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pulse_to_level;

    logic       clk;
    logic       rst_n;
    logic       pulse;
    logic [7:0] len;
    logic       retrig;
    logic       clr_drop;
    logic       level;
    logic       done;
    logic       busy;
    logic [7:0] drop_cnt;
    logic [1:0] p_STATE;

    int checks = 0;
    int errors = 0;

    pulse_to_level #(.WIDTH(8), .MIN_LOW(2)) dut (
        .i_clk    (clk),
        .rst_n    (rst_n),
        .pulse    (pulse),
        .len      (len),
        .retrig   (retrig),
        .clr_drop (clr_drop),
        .level    (level),
        .done     (done),
        .busy     (busy),
        .drop_cnt (drop_cnt),
        .p_STATE  (p_STATE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs until busy drops, counting level-high and done cycles
    task automatic run_out(output int nh, output int nd);
        int k;
        nh = 0;
        nd = 0;
        k  = 0;
        while (busy === 1'b1 && k < 1000) begin
            nh += int'(level);
            nd += int'(done);
            tick();
            k++;
        end
        chk("run_out_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int nh;
        int nd;
        rst_n = 1'b0; pulse = 1'b0; len = 8'd0; retrig = 1'b0; clr_drop = 1'b0;
        tick(); tick();
        chk("rst_state", {30'd0, p_STATE}, 32'd0);
        chk("rst_level", {31'd0, level}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_done",  {31'd0, done}, 32'd0);
        chk("rst_drop",  {24'd0, drop_cnt}, 32'd0);
        rst_n = 1'b1;
        tick();

        // basic len=4 timing
        pulse = 1'b1; len = 8'd4;
        tick();
        pulse = 1'b0;
        chk("l4_state_high", {30'd0, p_STATE}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("l4_level_hi", {31'd0, level}, 32'd1);
            chk("l4_done_lo", {31'd0, done}, 32'd0);
            tick();
        end
        chk("l4_level_fall", {31'd0, level}, 32'd0);
        chk("l4_done", {31'd0, done}, 32'd1);
        chk("l4_state_gap", {30'd0, p_STATE}, 32'd2);
        tick();
        chk("l4_done_once", {31'd0, done}, 32'd0);
        chk("l4_busy_gap2", {31'd0, busy}, 32'd1);
        tick();
        chk("l4_busy_end", {31'd0, busy}, 32'd0);
        chk("l4_state_idle", {30'd0, p_STATE}, 32'd0);

        // len=0 behaves as len=1
        pulse = 1'b1; len = 8'd0;
        tick();
        pulse = 1'b0;
        run_out(nh, nd);
        chk("l0_high_cycles", nh, 32'd1);
        chk("l0_done_count", nd, 32'd1);

        // len=255
        pulse = 1'b1; len = 8'd255;
        tick();
        pulse = 1'b0;
        run_out(nh, nd);
        chk("l255_high_cycles", nh, 32'd255);
        chk("l255_done_count", nd, 32'd1);

        // retrigger on the final HIGH cycle
        retrig = 1'b1; pulse = 1'b1; len = 8'd5;
        tick();
        pulse = 1'b0;
        nh = 0;
        for (int i = 0; i < 4; i++) begin
            nh += int'(level);
            tick();
        end
        nh += int'(level);
        pulse = 1'b1; len = 8'd3;
        tick();
        pulse = 1'b0;
        begin
            int nh2;
            run_out(nh2, nd);
            nh += nh2;
        end
        chk("retrig_high_cycles", nh, 32'd8);
        chk("retrig_done_count", nd, 32'd1);
        chk("retrig_no_drop", {24'd0, drop_cnt}, 32'd0);

        // drops during HIGH and on last GAP cycle
        retrig = 1'b0; pulse = 1'b1; len = 8'd4;
        tick();
        tick(); tick(); tick();
        pulse = 1'b0;
        tick();
        chk("drop_gap_done", {31'd0, done}, 32'd1);
        tick();
        pulse = 1'b1;
        tick();
        pulse = 1'b0;
        chk("drop_state_idle", {30'd0, p_STATE}, 32'd0);
        chk("drop_level_lo", {31'd0, level}, 32'd0);
        chk("drop_cnt4", {24'd0, drop_cnt}, 32'd4);
        tick();
        chk("drop_no_extra", {31'd0, level}, 32'd0);

        // saturation and clear priority
        clr_drop = 1'b1;
        tick();
        clr_drop = 1'b0;
        chk("clr_zero", {24'd0, drop_cnt}, 32'd0);
        pulse = 1'b1; len = 8'd255;
        for (int i = 0; i < 300; i++) tick();
        chk("sat_255", {24'd0, drop_cnt}, 32'd255);
        chk("sat_state_high", {30'd0, p_STATE}, 32'd1);
        clr_drop = 1'b1;
        tick();
        clr_drop = 1'b0; pulse = 1'b0;
        chk("clr_priority", {24'd0, drop_cnt}, 32'd0);
        rst_n = 1'b0; pulse = 1'b1;
        tick(); tick();
        chk("rst_ignore_pulse", {30'd0, p_STATE}, 32'd0);
        rst_n = 1'b1; pulse = 1'b0;
        tick();

        // reset mid-HIGH
        pulse = 1'b1; len = 8'd6;
        tick();
        pulse = 1'b0;
        tick();
        chk("mid_rst_pre_level", {31'd0, level}, 32'd1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_level", {31'd0, level}, 32'd0);
        chk("mid_rst_state", {30'd0, p_STATE}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        nd = int'(done);
        for (int i = 0; i < 8; i++) begin
            tick();
            nd += int'(done);
        end
        chk("mid_rst_no_done", nd, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
